// File: rtl/clkgen_cfg_pkg.sv
// clkgen_cfg_pkg: shared types and constants for the clk_generator config
// arbiter.
//   CLKGEN_DATA_W : width of clk_generator.datain and of each duty/phase field
//   state_e       : arbiter FSM state (3-bit encoding)
//   state_drives_go() : states in which clk_generator.go is held high
package clkgen_cfg_pkg;

  localparam int unsigned CLKGEN_DATA_W = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRE     = 3'd1,
    DUTY    = 3'd2,
    PHASE   = 3'd3,
    RUN     = 3'd4,
    RELEASE = 3'd5
  } state_e;

  function automatic logic state_drives_go(input state_e s);
    return (s == DUTY) || (s == PHASE) || (s == RUN);
  endfunction

endpackage

// File: rtl/clkgen_cfg_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req_i    : request vector
//   ptr_i    : highest-priority index this round
//   winner_o : one-hot winner (first set bit at/after ptr_i, wrapping)
//   idx_o    : binary index of winner
//   any_o    : at least one request set
module rr_picker #(
  parameter  int unsigned N     = 2,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     winner_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int unsigned      cand;
  logic [IDX_W-1:0] ci;

  always_comb begin
    winner_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    ci       = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = (32'(ptr_i) + off) % N;
      ci   = IDX_W'(cand);
      if (!any_o && req_i[ci]) begin
        any_o        = 1'b1;
        idx_o        = ci;
        winner_o[ci] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clkgen_cfg_arbiter.sv
// clkgen_cfg_arbiter: shares one clk_generator between NREQ requesters.
// The winner's duty/phase are latched at grant and loaded with the
// go/datain protocol (go=0/datain=0, duty, phase), then go stays high until
// the owner releases after at least MIN_RUN cycles.
//   clk, rst          : clock, asynchronous active-high reset
//   req[NREQ]         : level requests
//   cfg_duty/phase    : 3 bits per requester, sampled only at grant
//   grant[NREQ]       : one-hot owner, PRE through RUN
//   done, timed_out   : one-cycle pulses in RELEASE
//   go, datain        : to clk_generator
// Optional: define CLKGEN_CFG_TIMEOUT_EN to force release after TIMEOUT
// RUN cycles (timed_out pulses with done); otherwise timed_out is 0.
module clkgen_cfg_arbiter
  import clkgen_cfg_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned MIN_RUN = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NREQ-1:0]                 req,
  input  logic [CLKGEN_DATA_W*NREQ-1:0]   cfg_duty,
  input  logic [CLKGEN_DATA_W*NREQ-1:0]   cfg_phase,
  output logic [NREQ-1:0]                 grant,
  output logic                            done,
  output logic                            timed_out,
  output logic                            go,
  output logic [CLKGEN_DATA_W-1:0]        datain
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_RUN - 1);

  if ((64'd1 << CNT_W) < 64'(MIN_RUN) || (64'd1 << CNT_W) < 64'(TIMEOUT)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for MIN_RUN/TIMEOUT");
  end

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         owner_q, owner_d, ptr_q, ptr_d;
  logic [CLKGEN_DATA_W-1:0] duty_q, duty_d, phase_q, phase_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     go_q, go_d, done_q, done_d;
  logic [CLKGEN_DATA_W-1:0] datain_q, datain_d;
  logic [NREQ-1:0]          grant_q, grant_d;

  logic [NREQ-1:0]          win_oh;
  logic [IDX_W-1:0]         win_idx;
  logic                     win_any;

  logic [CLKGEN_DATA_W-1:0] duty_arr  [NREQ];
  logic [CLKGEN_DATA_W-1:0] phase_arr [NREQ];

  rr_picker #(.N(NREQ)) u_picker (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (win_oh),
    .idx_o    (win_idx),
    .any_o    (win_any)
  );

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      duty_arr[i]  = cfg_duty[i*CLKGEN_DATA_W +: CLKGEN_DATA_W];
      phase_arr[i] = cfg_phase[i*CLKGEN_DATA_W +: CLKGEN_DATA_W];
    end
  end

`ifdef CLKGEN_CFG_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT - 1);
  logic forced, tmo_q;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    duty_d  = duty_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
`ifdef CLKGEN_CFG_TIMEOUT_EN
    forced  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = PRE;
          owner_d = win_idx;
          duty_d  = duty_arr[win_idx];
          phase_d = phase_arr[win_idx];
        end
      end
      PRE:   state_d = DUTY;
      DUTY:  state_d = PHASE;
      PHASE: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        // Release decision uses the counter value before this increment.
        if (!req[owner_q] && (cnt_q >= MIN_CNT)) begin
          state_d = RELEASE;
        end
`ifdef CLKGEN_CFG_TIMEOUT_EN
        else if (cnt_q >= TMO_CNT) begin
          state_d = RELEASE;
          forced  = 1'b1;
        end
`endif
      end
      RELEASE: begin
        ptr_d   = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes from a flop.
  always_comb begin
    go_d     = state_drives_go(state_d);
    done_d   = (state_d == RELEASE);
    datain_d = '0;
    if (state_d == DUTY)  datain_d = duty_d;
    if (state_d == PHASE) datain_d = phase_d;
    grant_d = '0;
    if (state_q == IDLE && state_d == PRE) grant_d = win_oh;
    else if (state_drives_go(state_d))     grant_d = grant_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      duty_q   <= '0;
      phase_q  <= '0;
      cnt_q    <= '0;
      go_q     <= 1'b0;
      done_q   <= 1'b0;
      datain_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      duty_q   <= duty_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      go_q     <= go_d;
      done_q   <= done_d;
      datain_q <= datain_d;
      grant_q  <= grant_d;
    end
  end

`ifdef CLKGEN_CFG_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= 1'b0;
    else     tmo_q <= forced;
  end
  assign timed_out = tmo_q;
`else
  assign timed_out = 1'b0;
`endif

  assign go     = go_q;
  assign done   = done_q;
  assign datain = datain_q;
  assign grant  = grant_q;

endmodule

// File: tb/tb_clkgen_cfg_arbiter.sv
module tb_clkgen_cfg_arbiter;

  localparam int NREQ    = 2;
  localparam int MIN_RUN = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [5:0] cfg_duty, cfg_phase;
  logic [1:0] grant;
  logic       done, timed_out, go;
  logic [2:0] datain;

  clkgen_cfg_arbiter #(
    .NREQ(NREQ), .MIN_RUN(MIN_RUN), .CNT_W(8), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .cfg_duty(cfg_duty), .cfg_phase(cfg_phase),
    .grant(grant), .done(done), .timed_out(timed_out), .go(go), .datain(datain)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       g;
    logic [2:0] d;
    logic [1:0] gr;
    logic       dn;
    logic       tout;
  } exp_t;

  typedef struct {
    int         who;
    logic [2:0] duty;
    logic [2:0] phase;
    int         run;
    bit         early;
    bit         scr;
  } vec_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic exp_t mk(logic g, logic [2:0] d, logic [1:0] gr, logic dn, logic t);
    exp_t e;
    e = '{g: g, d: d, gr: gr, dn: dn, tout: t};
    return e;
  endfunction

  task automatic check_pop();
    exp_t  e, a;
    string nm;
    e = exp_q.pop_front();
    nm = nm_q.pop_front();
    a = {go, datain, grant, done, timed_out};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got go=%b datain=%b grant=%b done=%b timed_out=%b, want go=%b datain=%b grant=%b done=%b timed_out=%b",
               nm, $time, a.g, a.d, a.gr, a.dn, a.tout, e.g, e.d, e.gr, e.dn, e.tout);
    end
  endtask

  task automatic step(input exp_t e, input string nm);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(negedge clk);
    check_pop();
  endtask

  task automatic scramble();
    cfg_duty  = 6'($urandom);
    cfg_phase = 6'($urandom);
  endtask

  // One ownership: called at a negedge in IDLE; returns at a negedge in IDLE.
  task automatic txn(input int who, input logic [2:0] du, input logic [2:0] ph,
                     input int run, input bit early, input bit scr, input bit tmo);
    logic [1:0] oh;
    int         r;
    oh = 2'(1 << who);
    r  = early ? MIN_RUN : run;
    cfg_duty[who*3 +: 3]  = du;
    cfg_phase[who*3 +: 3] = ph;
    req[who] = 1'b1;
    step(mk(1'b0, 3'd0, oh, 1'b0, 1'b0), "pre");
    if (early) req[who] = 1'b0;
    if (scr) scramble();
    step(mk(1'b1, du, oh, 1'b0, 1'b0), "duty");
    step(mk(1'b1, ph, oh, 1'b0, 1'b0), "phase");
    for (int j = 0; j < r; j++) begin
      step(mk(1'b1, 3'd0, oh, 1'b0, 1'b0), "run");
      if (scr && j == 0) scramble();
      if (!early && !tmo && j == r - 1) req[who] = 1'b0;
    end
    step(mk(1'b0, 3'd0, 2'b00, 1'b1, tmo), "release");
    step(mk(1'b0, 3'd0, 2'b00, 1'b0, 1'b0), "idle");
  endtask

  vec_t vecs[6];
  exp_t zero;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    zero = mk(1'b0, 3'd0, 2'b00, 1'b0, 1'b0);
    vecs[0] = '{who: 0, duty: 3'b001, phase: 3'b011, run: 8, early: 1'b0, scr: 1'b0};
    vecs[1] = '{who: 1, duty: 3'b000, phase: 3'b000, run: 4, early: 1'b0, scr: 1'b0};
    vecs[2] = '{who: 1, duty: 3'b111, phase: 3'b101, run: 6, early: 1'b0, scr: 1'b1};
    vecs[3] = '{who: 0, duty: 3'b010, phase: 3'b110, run: 4, early: 1'b1, scr: 1'b0};
    vecs[4] = '{who: 1, duty: 3'b100, phase: 3'b010, run: 7, early: 1'b1, scr: 1'b1};
    vecs[5] = '{who: 0, duty: 3'b011, phase: 3'b111, run: 7, early: 1'b0, scr: 1'b0};

    rst = 1'b1; req = '0; cfg_duty = '0; cfg_phase = '0;
    step(zero, "reset");
    step(zero, "reset_hold");
    rst = 1'b0;
    step(zero, "idle_after_reset");

    // Single-requester table.
    foreach (vecs[i])
      txn(vecs[i].who, vecs[i].duty, vecs[i].phase, vecs[i].run, vecs[i].early, vecs[i].scr, 1'b0);

    // Pointer now 1: requester 1 wins a simultaneous request; reset it in PHASE.
    cfg_duty[5:3] = 3'b110; cfg_phase[5:3] = 3'b010;
    req = 2'b11;
    step(mk(1'b0, 3'd0, 2'b10, 1'b0, 1'b0), "mid_pre");
    step(mk(1'b1, 3'b110, 2'b10, 1'b0, 1'b0), "mid_duty");
    step(mk(1'b1, 3'b010, 2'b10, 1'b0, 1'b0), "mid_phase");
    #2 rst = 1'b1;
    #1;
    exp_q.push_back(zero); nm_q.push_back("async_reset");
    check_pop();
    step(zero, "reset_no_done");
    rst = 1'b0;

    // Simultaneous from reset: 0 first, then 1 (0 waiting), then 0 again.
    cfg_duty = {3'b110, 3'b101}; cfg_phase = {3'b010, 3'b001};
    txn(0, 3'b101, 3'b001, 4, 1'b0, 1'b0, 1'b0);
    req[0] = 1'b1;
    txn(1, 3'b110, 3'b010, 5, 1'b0, 1'b0, 1'b0);
    txn(0, 3'b101, 3'b001, 4, 1'b0, 1'b0, 1'b0);

`ifdef CLKGEN_CFG_TIMEOUT_EN
    // Requester 0 holds forever: forced release after 8 RUN cycles, 1 next.
    req = 2'b11;
    txn(0, 3'b011, 3'b100, 8, 1'b0, 1'b0, 1'b1);
    txn(1, 3'b001, 3'b001, 4, 1'b0, 1'b0, 1'b0);
    txn(0, 3'b011, 3'b100, 5, 1'b0, 1'b0, 1'b0);
`endif

    step(zero, "final_idle");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
